// File: rtl/rv32_pipe_ctrl.sv
// Pipeline control for a 5-stage RV32 core: stall, flush and bubble generation,
// data-memory wait tracking with timeout, halt freeze, and stall/flush statistics.
module rv32_pipe_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic [4:0]  ex_rd,
  input  logic        ex_is_load,
  input  logic        branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic        halt_req,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        ex_mem_en,
  output logic        mem_wb_en,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        halted,
  output logic        mem_fault,
  output logic [15:0] stall_cnt,
  output logic [7:0]  flush_cnt
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALTED, FAULT} state_t;

  localparam logic [7:0] TIMEOUT_W = 8'(MEM_TIMEOUT);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       hazard, mem_wait, normal, fault_set, active;
  logic       pc_en_c, if_id_en_c, id_ex_en_c, ex_mem_en_c, mem_wb_en_c;
  logic       flush_c, bubble_c;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign hazard = ex_is_load && (ex_rd != 5'd0) &&
                  ((id_rs1_used && (id_rs1 == ex_rd)) ||
                   (id_rs2_used && (id_rs2 == ex_rd)));
  assign mem_wait = mem_req && !mem_ready;
  assign active   = (state == RUN) || (state == MEM_WAIT);

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    normal       = 1'b0;
    fault_set    = 1'b0;
    pc_en_c      = 1'b0;
    if_id_en_c   = 1'b0;
    id_ex_en_c   = 1'b0;
    ex_mem_en_c  = 1'b0;
    mem_wb_en_c  = 1'b0;
    flush_c      = 1'b0;
    bubble_c     = 1'b0;
    case (state)
      RUN: begin
        if (mem_wait) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = 8'd1;
        end else begin
          normal = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!mem_ready) begin
          if (wait_cnt == TIMEOUT_W) begin
            state_nxt = FAULT;
            fault_set = 1'b1;
          end else begin
            wait_cnt_nxt = wait_cnt + 8'd1;
          end
        end else begin
          normal       = 1'b1;
          state_nxt    = RUN;
          wait_cnt_nxt = 8'd0;
        end
      end
      default: ;
    endcase
    // Branch flush wins over load-use: the stalled ID instruction is squashed anyway.
    if (normal) begin
      if (branch_taken) begin
        {pc_en_c, if_id_en_c, id_ex_en_c, ex_mem_en_c, mem_wb_en_c} = 5'b11111;
        flush_c  = 1'b1;
        bubble_c = 1'b1;
      end else if (hazard) begin
        {pc_en_c, if_id_en_c, id_ex_en_c, ex_mem_en_c, mem_wb_en_c} = 5'b00111;
        bubble_c = 1'b1;
      end else begin
        {pc_en_c, if_id_en_c, id_ex_en_c, ex_mem_en_c, mem_wb_en_c} = 5'b11111;
      end
    end
    if (active && halt_req && !fault_set) state_nxt = HALTED;
  end

  // While in reset, queues are held loading NOPs.
  assign pc_en        = rst_n & pc_en_c;
  assign if_id_en     = rst_n & if_id_en_c;
  assign id_ex_en     = rst_n & id_ex_en_c;
  assign ex_mem_en    = rst_n & ex_mem_en_c;
  assign mem_wb_en    = rst_n & mem_wb_en_c;
  assign if_id_flush  = ~rst_n | flush_c;
  assign id_ex_bubble = ~rst_n | bubble_c;
  assign halted       = (state == HALTED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      wait_cnt  <= 8'd0;
      stall_cnt <= 16'd0;
      flush_cnt <= 8'd0;
      mem_fault <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (active && !pc_en_c)         stall_cnt <= sat_inc16(stall_cnt);
      if (normal && branch_taken)     flush_cnt <= flush_cnt + 8'd1;
      if (fault_set)                  mem_fault <= 1'b1;
    end
  end

endmodule
